// File: rtl/systolic_tile_sequencer_pkg.sv
// rtl/systolic_tile_sequencer_pkg.sv - shared types and phase-boundary helpers for the tile sequencer
package systolic_tile_sequencer_pkg;

    localparam int DEF_SIZE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Phase boundaries in RUN-cycle units (t = 0 on the first RUN cycle).
    function automatic int load_cyc(input int n);
        return n;
    endfunction

    function automatic int stream_first(input int n);
        return n - 1;
    endfunction

    function automatic int stream_last(input int n);
        return 3 * n - 3;
    endfunction

    function automatic int last_res(input int n, input int res_lat);
        return res_lat + 2 * n - 2;
    endfunction

endpackage

// File: rtl/sa_diag_index_gen.sv
// rtl/sa_diag_index_gen.sv - per-lane diagonal valid/index decode from a cycle count and fixed offset
module sa_diag_index_gen
    import systolic_tile_sequencer_pkg::*;
#(
    parameter int N      = DEF_SIZE,
    parameter int ADDR_W = $clog2(DEF_SIZE),
    parameter int CNT_W  = $clog2(4 * DEF_SIZE) + 1,
    parameter int OFFSET = DEF_SIZE - 1
) (
    input  logic                  en,
    input  logic [CNT_W-1:0]      t,
    output logic [N-1:0]          lane_valid,
    output logic [N*ADDR_W-1:0]   lane_idx
);

    int rel;

    // Lane k sees element (t - OFFSET - k) of its diagonal; outside 0..N-1 the lane is idle.
    always_comb begin
        lane_valid = '0;
        lane_idx   = '0;
        rel        = 0;
        for (int k = 0; k < N; k++) begin
            rel = int'(t) - OFFSET - k;
            if (en && (rel >= 0) && (rel < N)) begin
                lane_valid[k]                 = 1'b1;
                lane_idx[k*ADDR_W +: ADDR_W]  = ADDR_W'(rel);
            end
        end
    end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - sequences weight load, skewed activation stream and result de-skew for one tile
module systolic_tile_sequencer
    import systolic_tile_sequencer_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEF_SIZE,
    parameter int ADDR_W        = $clog2(SYSTOLIC_SIZE),
    parameter int RES_LAT       = 2 * SYSTOLIC_SIZE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              ready,
    input  logic                              abort,
    input  logic                              scan_en_req,
    input  logic [SYSTOLIC_SIZE-1:0]          pe_disable_cfg,
    output logic [SYSTOLIC_SIZE-1:0]          pe_disable,
    output logic                              clk_w_en,
    output logic                              w_rd_en,
    output logic [ADDR_W-1:0]                 w_col,
    output logic [SYSTOLIC_SIZE-1:0]          a_lane_valid,
    output logic [SYSTOLIC_SIZE*ADDR_W-1:0]   a_lane_row,
    output logic [SYSTOLIC_SIZE*ADDR_W-1:0]   a_lane_col,
    output logic [SYSTOLIC_SIZE-1:0]          res_lane_valid,
    output logic [SYSTOLIC_SIZE*ADDR_W-1:0]   res_lane_col,
    output logic                              busy,
    output logic                              done
);

    localparam int N     = SYSTOLIC_SIZE;
    localparam int CNT_W = $clog2(4 * N) + 1;

    localparam logic [CNT_W-1:0]  LOAD_T  = CNT_W'(load_cyc(N));
    localparam logic [CNT_W-1:0]  LAST_T  = CNT_W'(last_res(N, RES_LAT));
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(N - 1);

    seq_state_e state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic [N-1:0]     pe_disable_q, pe_disable_d;

    logic                clk_w_en_q, clk_w_en_d;
    logic                w_rd_en_q, w_rd_en_d;
    logic [ADDR_W-1:0]   w_col_q, w_col_d;
    logic [N-1:0]        a_lane_valid_q, a_lane_valid_d;
    logic [N*ADDR_W-1:0] a_lane_row_q, a_lane_row_d;
    logic [N*ADDR_W-1:0] a_lane_col_q, a_lane_col_d;
    logic [N-1:0]        res_lane_valid_q, res_lane_valid_d;
    logic [N*ADDR_W-1:0] res_lane_col_q, res_lane_col_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic run_d;
    logic accept;

    assign ready  = (state_q == ST_IDLE) && !scan_en_req;
    assign accept = start && ready && !abort;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        pe_disable_d = pe_disable_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_RUN;
                    t_d          = '0;
                    pe_disable_d = pe_disable_cfg;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                end else if (t_q == LAST_T) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state/count so that they line up with t in the same cycle.
    assign run_d = (state_d == ST_RUN);

    sa_diag_index_gen #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .OFFSET (stream_first(N))
    ) u_act_skew (
        .en         (run_d),
        .t          (t_d),
        .lane_valid (a_lane_valid_d),
        .lane_idx   (a_lane_row_d)
    );

    sa_diag_index_gen #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .OFFSET (RES_LAT)
    ) u_res_deskew (
        .en         (run_d),
        .t          (t_d),
        .lane_valid (res_lane_valid_d),
        .lane_idx   (res_lane_col_d)
    );

    always_comb begin
        clk_w_en_d   = 1'b0;
        w_rd_en_d    = 1'b0;
        w_col_d      = '0;
        a_lane_col_d = '0;
        busy_d       = run_d;
        done_d       = (state_d == ST_DONE);
        if (run_d && (t_d < LOAD_T)) begin
            clk_w_en_d = 1'b1;
            w_rd_en_d  = 1'b1;
            w_col_d    = COL_MAX - t_d[ADDR_W-1:0];
        end
        for (int k = 0; k < N; k++) begin
            if (a_lane_valid_d[k]) begin
                a_lane_col_d[k*ADDR_W +: ADDR_W] = ADDR_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            t_q              <= '0;
            pe_disable_q     <= '0;
            clk_w_en_q       <= 1'b0;
            w_rd_en_q        <= 1'b0;
            w_col_q          <= '0;
            a_lane_valid_q   <= '0;
            a_lane_row_q     <= '0;
            a_lane_col_q     <= '0;
            res_lane_valid_q <= '0;
            res_lane_col_q   <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            t_q              <= t_d;
            pe_disable_q     <= pe_disable_d;
            clk_w_en_q       <= clk_w_en_d;
            w_rd_en_q        <= w_rd_en_d;
            w_col_q          <= w_col_d;
            a_lane_valid_q   <= a_lane_valid_d;
            a_lane_row_q     <= a_lane_row_d;
            a_lane_col_q     <= a_lane_col_d;
            res_lane_valid_q <= res_lane_valid_d;
            res_lane_col_q   <= res_lane_col_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign pe_disable     = pe_disable_q;
    assign clk_w_en       = clk_w_en_q;
    assign w_rd_en        = w_rd_en_q;
    assign w_col          = w_col_q;
    assign a_lane_valid   = a_lane_valid_q;
    assign a_lane_row     = a_lane_row_q;
    assign a_lane_col     = a_lane_col_q;
    assign res_lane_valid = res_lane_valid_q;
    assign res_lane_col   = res_lane_col_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
